// File: rtl/div_monitor_pkg.sv
// Shared state encoding and ratio-derived constants for the divided-clock monitor.
package div_monitor_pkg;

    typedef enum logic [1:0] {
        SEEK,
        MEAS,
        LOCK
    } state_t;

    // Acceptable high-time window: floor and ceiling of half the ratio.
    function automatic int duty_lo(input int fdiv);
        return fdiv / 2;
    endfunction

    function automatic int duty_hi(input int fdiv);
        return (fdiv + 1) / 2;
    endfunction

    function automatic int tmo(input int fdiv);
        return 2 * fdiv;
    endfunction

endpackage

// File: rtl/div_clk_monitor_edge_sample.sv
// Two-stage sampler of the divided clock in the source domain, with rising-edge detect.
module edge_sample (
    input  logic clk_in,
    input  logic rst,
    input  logic div_clk,
    output logic s0,
    output logic rise
);

    logic s1;

    // div_clk is generated from clk_in, so no synchroniser stage is needed.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= div_clk;
            s1 <= s0;
        end
    end

    assign rise = s0 & ~s1;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of the divided clock, flags ratio/duty errors,
// tracks lock and reports loss of clock.
module div_clk_monitor
    import div_monitor_pkg::*;
#(
    parameter int FDIV   = 7,
    parameter int CW     = 8,
    parameter int LOCK_N = 4
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          div_clk,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt,
    output logic          meas_valid,
    output logic          freq_err,
    output logic          duty_err,
    output logic          locked,
    output logic          timeout
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] FDIV_C  = CW'(FDIV);
    localparam logic [CW-1:0] DUTY_LO = CW'(duty_lo(FDIV));
    localparam logic [CW-1:0] DUTY_HI = CW'(duty_hi(FDIV));
    localparam logic [CW-1:0] TMO_C   = CW'(tmo(FDIV));
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_N);

    logic          s0;
    logic          rise;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] high_acc;
    logic [GW-1:0] good_cnt;
    logic          f_bad;
    logic          d_bad;
    state_t        state;

    edge_sample u_edge_sample (
        .clk_in  (clk_in),
        .rst     (rst),
        .div_clk (div_clk),
        .s0      (s0),
        .rise    (rise)
    );

    always_comb begin
        f_bad = 1'b0;
        d_bad = 1'b0;
        f_bad = (cyc_cnt != FDIV_C);
        d_bad = !((high_acc == DUTY_LO) || (high_acc == DUTY_HI));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= SEEK;
            cyc_cnt    <= '0;
            high_acc   <= '0;
            good_cnt   <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            freq_err   <= 1'b0;
            duty_err   <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (rise) begin
                cyc_cnt  <= CW'(1);
                high_acc <= CW'(1);
            end else begin
                cyc_cnt  <= (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CW'(1);
                high_acc <= (high_acc == CNT_MAX) ? high_acc : high_acc + CW'(s0);
            end

            // A rise always takes priority over the timeout threshold.
            if (rise) begin
                timeout <= 1'b0;
                if (state == SEEK) begin
                    state <= MEAS;
                end else begin
                    period     <= cyc_cnt;
                    high_cnt   <= high_acc;
                    freq_err   <= f_bad;
                    duty_err   <= d_bad;
                    meas_valid <= 1'b1;
                    if (f_bad || d_bad) begin
                        state    <= MEAS;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end else if (state == MEAS) begin
                        good_cnt <= good_cnt + GW'(1);
                        if (good_cnt + GW'(1) == LOCK_TGT) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end
                    end
                end
            end else if (cyc_cnt >= TMO_C) begin
                state    <= SEEK;
                timeout  <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor with FDIV=7, CW=8, LOCK_N=4.
module tb_div_clk_monitor;

    logic       clk_in;
    logic       rst;
    logic       div_clk;
    logic [7:0] period;
    logic [7:0] high_cnt;
    logic       meas_valid;
    logic       freq_err;
    logic       duty_err;
    logic       locked;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int meas_cnt = 0;
    bit tmo_seen = 1'b0;

    div_clk_monitor #(.FDIV(7), .CW(8), .LOCK_N(4)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_clk    (div_clk),
        .period     (period),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .freq_err   (freq_err),
        .duty_err   (duty_err),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial clk_in = 1'b0;
    always #20 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v);
        div_clk = v;
        @(posedge clk_in);
        #1;
        if (meas_valid === 1'b1) meas_cnt++;
        if (timeout === 1'b1) tmo_seen = 1'b1;
    endtask

    task automatic run_period(input int n, input int h);
        for (int i = 0; i < n; i++) cyc(i < h);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_high"}, 32'(high_cnt), 0);
        chk({tag, "_mv"}, 32'(meas_valid), 0);
        chk({tag, "_ferr"}, 32'(freq_err), 0);
        chk({tag, "_derr"}, 32'(duty_err), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_tmo"}, 32'(timeout), 0);
    endtask

    initial begin
        div_clk = 1'b0;
        rst = 1'b0;
        #12 rst = 1'b1;
        #2 chk_all_zero("reset");
        #3 rst = 1'b0;
        @(posedge clk_in);
        #1;

        // Nominal ratio 7, high 3: first measurement needs two rises, lock after five.
        run_period(7, 3);
        chk("t1_no_meas_after_first_rise", 32'(meas_cnt), 0);
        run_period(7, 3);
        chk("t1_meas_cnt", 32'(meas_cnt), 1);
        chk("t1_period", 32'(period), 7);
        chk("t1_high", 32'(high_cnt), 3);
        chk("t1_ferr", 32'(freq_err), 0);
        chk("t1_derr", 32'(duty_err), 0);
        chk("t1_locked_early", 32'(locked), 0);
        run_period(7, 3);
        run_period(7, 3);
        chk("t1_locked_after_4th", 32'(locked), 0);
        run_period(7, 3);
        chk("t1_locked_after_5th", 32'(locked), 1);
        chk("t1_meas_cnt4", 32'(meas_cnt), 4);
        tmo_seen = 1'b0;
        for (int i = 0; i < 3; i++) run_period(7, 3);
        chk("t1_no_timeout", 32'(tmo_seen), 0);
        chk("t1_still_locked", 32'(locked), 1);

        // One short-high period breaks lock; four good ones restore it.
        run_period(7, 2);
        run_period(7, 3);
        chk("t3_derr", 32'(duty_err), 1);
        chk("t3_high", 32'(high_cnt), 2);
        chk("t3_period", 32'(period), 7);
        chk("t3_unlocked", 32'(locked), 0);
        run_period(7, 3);
        chk("t3_derr_clear", 32'(duty_err), 0);
        run_period(7, 3);
        run_period(7, 3);
        chk("t3_not_yet_relocked", 32'(locked), 0);
        run_period(7, 3);
        chk("t3_relocked", 32'(locked), 1);

        // Loss of clock: threshold reached 14 cycles after the last rise.
        for (int i = 0; i < 8; i++) cyc(1'b0);
        chk("t4_tmo_before", 32'(timeout), 0);
        chk("t4_locked_before", 32'(locked), 1);
        cyc(1'b0);
        chk("t4_tmo", 32'(timeout), 1);
        chk("t4_unlocked", 32'(locked), 0);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        chk("t4_tmo_held", 32'(timeout), 1);
        begin
            int mc;
            mc = meas_cnt;
            run_period(7, 3);
            chk("t4_tmo_cleared", 32'(timeout), 0);
            chk("t4_no_meas_first_rise", 32'(meas_cnt - mc), 0);
            run_period(7, 3);
            chk("t4_meas_second_rise", 32'(meas_cnt - mc), 1);
            chk("t4_period", 32'(period), 7);
        end

        // Period exactly at the timeout threshold: measured, no timeout.
        tmo_seen = 1'b0;
        run_period(14, 3);
        run_period(7, 4);
        chk("t6_period", 32'(period), 14);
        chk("t6_ferr", 32'(freq_err), 1);
        chk("t6_derr", 32'(duty_err), 0);
        chk("t6_no_tmo", 32'(tmo_seen), 0);
        run_period(7, 4);
        chk("t6_high4", 32'(high_cnt), 4);
        chk("t6_ferr_clear", 32'(freq_err), 0);
        run_period(7, 4);
        run_period(7, 4);
        chk("t6_not_locked", 32'(locked), 0);
        run_period(7, 4);
        chk("t6_relocked", 32'(locked), 1);

        // Asynchronous reset in mid-period while locked.
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        #5 rst = 1'b1;
        #2 chk_all_zero("t5_rst");
        #5 rst = 1'b0;
        begin
            int mc;
            mc = meas_cnt;
            run_period(7, 3);
            chk("t5_no_meas_first_rise", 32'(meas_cnt - mc), 0);
            run_period(7, 3);
            chk("t5_meas_second_rise", 32'(meas_cnt - mc), 1);
            chk("t5_period", 32'(period), 7);
            chk("t5_high", 32'(high_cnt), 3);
        end

        // Wrong ratio 8 with legal duty: freq_err on every measurement, no lock.
        run_period(8, 4);
        for (int i = 0; i < 4; i++) begin
            int mc;
            mc = meas_cnt;
            run_period(8, 4);
            chk("t2_meas", 32'(meas_cnt - mc), 1);
            chk("t2_period", 32'(period), 8);
            chk("t2_ferr", 32'(freq_err), 1);
            chk("t2_derr", 32'(duty_err), 0);
            chk("t2_locked", 32'(locked), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
